// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA timing / test-pattern generator.
// The timing struct collects the raster geometry; bar colours are RGB on/off masks.
package vga_pkg;

  typedef struct packed {
    int unsigned h_disp;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_disp;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } timing_t;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_BLACK = 2'd3
  } pattern_e;

  // {R,G,B} masks, left to right: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [2:0] BAR_RGB [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                         3'b101, 3'b100, 3'b001, 3'b000};

  function automatic int unsigned h_total(input timing_t t);
    return t.h_disp + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic int unsigned v_total(input timing_t t);
    return t.v_disp + t.v_fp + t.v_sync + t.v_bp;
  endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Test-pattern colour source: one registered stage from (x, y, active, pattern) to RGB.
// Outside the active region every channel is forced to zero.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned RGB_W  = 10,
  parameter int unsigned X_W    = 10,
  parameter int unsigned Y_W    = 10,
  parameter int unsigned H_DISP = 640
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             ce_i,
  input  logic [X_W-1:0]   x_i,
  input  logic [Y_W-1:0]   y_i,
  input  logic             active_i,
  input  pattern_e         pat_i,
  output logic [RGB_W-1:0] r_o,
  output logic [RGB_W-1:0] g_o,
  output logic [RGB_W-1:0] b_o
);

  localparam int unsigned BAR_W = H_DISP / 8;

  logic [2:0]       bar_idx;
  logic [2:0]       bar_mask;
  logic             chk;
  logic [RGB_W-1:0] grad;
  logic [RGB_W-1:0] r_d, g_d, b_d;
  logic [RGB_W-1:0] r_q, g_q, b_q;

  assign bar_idx  = 3'(x_i / X_W'(BAR_W));
  assign bar_mask = BAR_RGB[bar_idx];
  // 32-pixel squares: bit 5 of each coordinate selects the square parity
  assign chk      = (|(x_i & X_W'(32))) ^ (|(y_i & Y_W'(32)));

  generate
    if (X_W >= RGB_W) begin : g_grad_trunc
      assign grad = x_i[X_W-1 -: RGB_W];
    end else begin : g_grad_pad
      assign grad = {x_i, {(RGB_W - X_W){1'b0}}};
    end
  endgenerate

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (active_i) begin
      case (pat_i)
        PAT_BARS: begin
          r_d = {RGB_W{bar_mask[2]}};
          g_d = {RGB_W{bar_mask[1]}};
          b_d = {RGB_W{bar_mask[0]}};
        end
        PAT_CHECK: begin
          r_d = {RGB_W{chk}};
          g_d = {RGB_W{chk}};
          b_d = {RGB_W{chk}};
        end
        PAT_GRAD: begin
          r_d = grad;
          g_d = grad;
          b_d = grad;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else if (ce_i) begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  assign r_o = r_q;
  assign g_o = g_q;
  assign b_o = b_q;

endmodule

// File: rtl/vga_timing_pattern_gen.sv
// Parametrised VGA raster timing generator with built-in test patterns.
// All outputs are registered one CE cycle behind the raster counters.
module vga_timing_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned RGB_W  = 10,
  parameter int unsigned H_DISP = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_DISP = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  parameter bit          HS_POL = 1'b0,
  parameter bit          VS_POL = 1'b0
) (
  input  logic                                            CLK,
  input  logic                                            RST,
  input  logic                                            CE,
  input  logic [1:0]                                      PAT_SEL,
  output logic                                            VGA_HS,
  output logic                                            VGA_VS,
  output logic                                            VGA_BLANK,
  output logic                                            VGA_SYNC,
  output logic [RGB_W-1:0]                                VGA_R,
  output logic [RGB_W-1:0]                                VGA_G,
  output logic [RGB_W-1:0]                                VGA_B,
  output logic [$clog2(H_DISP+H_FP+H_SYNC+H_BP)-1:0]      PIX_X,
  output logic [$clog2(V_DISP+V_FP+V_SYNC+V_BP)-1:0]      PIX_Y,
  output logic                                            FRAME_START
);

  localparam timing_t TIMING = '{h_disp: H_DISP, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
                                 v_disp: V_DISP, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP};
  localparam int unsigned H_TOT  = h_total(TIMING);
  localparam int unsigned V_TOT  = v_total(TIMING);
  localparam int unsigned X_W    = $clog2(H_TOT);
  localparam int unsigned Y_W    = $clog2(V_TOT);
  localparam int unsigned HS_BEG = TIMING.h_disp + TIMING.h_fp;
  localparam int unsigned HS_END = HS_BEG + TIMING.h_sync;
  localparam int unsigned VS_BEG = TIMING.v_disp + TIMING.v_fp;
  localparam int unsigned VS_END = VS_BEG + TIMING.v_sync;

  generate
    if ((H_DISP % 8) != 0) begin : g_bad_h_disp
      $error("vga_timing_pattern_gen: H_DISP must be divisible by 8");
    end
  endgenerate

  logic [X_W-1:0] hcnt_q, hcnt_d;
  logic [Y_W-1:0] vcnt_q, vcnt_d;
  pattern_e       pat_q, pat_cur;
  logic           frame_first, active, hs_on, vs_on;
  logic           hs_q, vs_q, blank_q, fs_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;

  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == X_W'(H_TOT - 1)) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == Y_W'(V_TOT - 1)) ? '0 : vcnt_q + 1'b1;
    end
  end

  assign frame_first = (hcnt_q == '0) && (vcnt_q == '0);
  assign active      = (32'(hcnt_q) < TIMING.h_disp) && (32'(vcnt_q) < TIMING.v_disp);
  assign hs_on       = (32'(hcnt_q) >= HS_BEG) && (32'(hcnt_q) < HS_END);
  assign vs_on       = (32'(vcnt_q) >= VS_BEG) && (32'(vcnt_q) < VS_END);
  // The first pixel of a frame already uses the freshly sampled pattern
  assign pat_cur     = frame_first ? pattern_e'(PAT_SEL) : pat_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      pat_q   <= PAT_BARS;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      blank_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
    end else if (CE) begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      if (frame_first) pat_q <= pattern_e'(PAT_SEL);
      hs_q    <= hs_on ? HS_POL : ~HS_POL;
      vs_q    <= vs_on ? VS_POL : ~VS_POL;
      blank_q <= active;
      x_q     <= hcnt_q;
      y_q     <= vcnt_q;
      fs_q    <= frame_first;
    end
  end

  vga_pattern_gen #(
    .RGB_W  (RGB_W),
    .X_W    (X_W),
    .Y_W    (Y_W),
    .H_DISP (H_DISP)
  ) u_pattern (
    .clk_i    (CLK),
    .srst_i   (RST),
    .ce_i     (CE),
    .x_i      (hcnt_q),
    .y_i      (vcnt_q),
    .active_i (active),
    .pat_i    (pat_cur),
    .r_o      (VGA_R),
    .g_o      (VGA_G),
    .b_o      (VGA_B)
  );

  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK   = blank_q;
  assign VGA_SYNC    = 1'b0;
  assign PIX_X       = x_q;
  assign PIX_Y       = y_q;
  assign FRAME_START = fs_q;

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Bench for vga_timing_pattern_gen on a reduced raster (160x58 total) so whole frames fit.
// Table vectors, timing measurements, hand sequences and a randomized run against a pixel-index model.
module tb_vga_timing_pattern_gen;

  localparam int HD = 128, HF = 8, HSY = 16, HB = 8;
  localparam int VD = 48,  VF = 3, VSY = 2,  VB = 5;
  localparam int HT = HD + HF + HSY + HB;   // 160
  localparam int VT = VD + VF + VSY + VB;   // 58
  localparam int FRAME = HT * VT;           // 9280
  localparam int XW = 8, YW = 6, CW = 10;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          blank;
    logic          sync;
    logic          fs;
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } exp_t;

  typedef struct {
    logic [1:0]    pat;
    int            x;
    int            y;
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
    logic          blank;
  } vec_t;

  logic          clk = 1'b0;
  logic          RST, CE;
  logic [1:0]    PAT_SEL;
  logic          VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, FRAME_START;
  logic [CW-1:0] VGA_R, VGA_G, VGA_B;
  logic [XW-1:0] PIX_X;
  logic [YW-1:0] PIX_Y;

  always #5 clk = ~clk;

  vga_timing_pattern_gen #(
    .RGB_W(CW), .H_DISP(HD), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_DISP(VD), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .CLK(clk), .RST(RST), .CE(CE), .PAT_SEL(PAT_SEL),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK), .VGA_SYNC(VGA_SYNC),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .PIX_X(PIX_X), .PIX_Y(PIX_Y), .FRAME_START(FRAME_START)
  );

  exp_t act_s;
  assign act_s = {VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, FRAME_START,
                  VGA_R, VGA_G, VGA_B, PIX_X, PIX_Y};

  function automatic exp_t reset_exp();
    exp_t e;
    e    = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    return e;
  endfunction

  // Expected registered outputs when the raster shows pixel (x, y) with pattern pat
  function automatic exp_t ref_pixel(input int x, input int y, input int pat);
    exp_t       e;
    logic [2:0] m;
    logic [CW-1:0] lvl;
    bit         act;
    e       = '0;
    e.x     = XW'(x);
    e.y     = YW'(y);
    e.fs    = (x == 0) && (y == 0);
    e.hs    = (x >= HD + HF && x < HD + HF + HSY) ? 1'b0 : 1'b1;
    e.vs    = (y >= VD + VF && y < VD + VF + VSY) ? 1'b0 : 1'b1;
    act     = (x < HD) && (y < VD);
    e.blank = act;
    if (act) begin
      case (pat)
        0: begin
          case (x / (HD / 8))
            0: m = 3'b111;  // white
            1: m = 3'b110;  // yellow
            2: m = 3'b011;  // cyan
            3: m = 3'b010;  // green
            4: m = 3'b101;  // magenta
            5: m = 3'b100;  // red
            6: m = 3'b001;  // blue
            default: m = 3'b000;
          endcase
          e.r = m[2] ? '1 : '0;
          e.g = m[1] ? '1 : '0;
          e.b = m[0] ? '1 : '0;
        end
        1: begin
          lvl = (((x / 32) % 2) != ((y / 32) % 2)) ? '1 : '0;
          e.r = lvl; e.g = lvl; e.b = lvl;
        end
        2: begin
          lvl = CW'(x * (1 << (CW - XW)));
          e.r = lvl; e.g = lvl; e.b = lvl;
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  // Reference model: linear pixel index within the frame, pattern captured at pixel 0
  exp_t       mdl_q;
  int         pix_q;
  logic [1:0] mpat_q;
  always @(posedge clk) begin
    if (RST) begin
      mdl_q  <= reset_exp();
      pix_q  <= 0;
      mpat_q <= 2'd0;
    end else if (CE) begin
      mdl_q  <= ref_pixel(pix_q % HT, pix_q / HT, (pix_q == 0) ? int'(PAT_SEL) : int'(mpat_q));
      if (pix_q == 0) mpat_q <= PAT_SEL;
      pix_q  <= (pix_q + 1) % FRAME;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit mdl_chk = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (mdl_chk) check("model", 64'(act_s), 64'(mdl_q));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    CE  = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic hs_measure(input bit toggle, output int fall_x, output int low_cyc,
                            output int period);
    int   fall1 = -1, fall2 = -1, rise = -1;
    logic prev  = 1'b1;
    fall_x = -1;
    for (int t = 0; t < 1000 && fall2 < 0; t++) begin
      CE = toggle ? ((t % 2) == 0) : 1'b1;
      tick();
      if (prev && !VGA_HS) begin
        if (fall1 < 0) begin
          fall1  = t;
          fall_x = int'(PIX_X);
        end else begin
          fall2 = t;
        end
      end
      if (!prev && VGA_HS && fall1 >= 0 && rise < 0) rise = t;
      prev = VGA_HS;
    end
    low_cyc = (rise >= 0 && fall1 >= 0) ? rise - fall1 : -1;
    period  = (fall2 >= 0) ? fall2 - fall1 : -1;
    CE = 1'b1;
  endtask

  vec_t vec [12];

  initial begin
    int fx, lc, per, fs1, fs2, vs_low, vs_y;
    logic prev_vs;
    exp_t e;

    vec[0]  = '{2'd0,   0,  0, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1};
    vec[1]  = '{2'd0,  16,  0, 10'h3FF, 10'h3FF, 10'h000, 1'b1};
    vec[2]  = '{2'd0,  80,  2, 10'h3FF, 10'h000, 10'h000, 1'b1};
    vec[3]  = '{2'd0, 127,  1, 10'h000, 10'h000, 10'h000, 1'b1};
    vec[4]  = '{2'd0, 128,  1, 10'h000, 10'h000, 10'h000, 1'b0};
    vec[5]  = '{2'd1,  32,  0, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1};
    vec[6]  = '{2'd1,  32, 32, 10'h000, 10'h000, 10'h000, 1'b1};
    vec[7]  = '{2'd1,   0, 33, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1};
    vec[8]  = '{2'd1,  64, 40, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1};
    vec[9]  = '{2'd2, 100,  3, 10'h190, 10'h190, 10'h190, 1'b1};
    vec[10] = '{2'd3,   5,  5, 10'h000, 10'h000, 10'h000, 1'b1};
    vec[11] = '{2'd0,  10, 48, 10'h000, 10'h000, 10'h000, 1'b0};

    RST = 1'b1; CE = 1'b0; PAT_SEL = 2'd0;

    // Reset values after two reset cycles with CE high
    do_reset();
    check("reset_values", 64'(act_s), 64'(reset_exp()));
    mdl_chk = 1'b1;

    // Table-driven pixel colour / blanking checks
    for (int i = 0; i < 12; i++) begin
      PAT_SEL = vec[i].pat;
      do_reset();
      repeat (vec[i].y * HT + vec[i].x + 1) tick();
      check($sformatf("vec%0d_p%0d_x%0d_y%0d", i, vec[i].pat, vec[i].x, vec[i].y),
            64'({VGA_BLANK, VGA_R, VGA_G, VGA_B, PIX_X, PIX_Y}),
            64'({vec[i].blank, vec[i].r, vec[i].g, vec[i].b, XW'(vec[i].x), YW'(vec[i].y)}));
    end

    // Horizontal sync timing, CE constant then CE toggling
    PAT_SEL = 2'd0;
    do_reset();
    hs_measure(1'b0, fx, lc, per);
    check("hs_start_x", 64'(fx), 64'(HD + HF));
    check("hs_low_cycles", 64'(lc), 64'(HSY));
    check("line_period", 64'(per), 64'(HT));
    do_reset();
    hs_measure(1'b1, fx, lc, per);
    check("hs_start_x_ce2", 64'(fx), 64'(HD + HF));
    check("hs_low_cycles_ce2", 64'(lc), 64'(2 * HSY));
    check("line_period_ce2", 64'(per), 64'(2 * HT));

    // Frame period and vertical sync
    do_reset();
    fs1 = -1; fs2 = -1; vs_low = 0; vs_y = -1; prev_vs = 1'b1;
    for (int t = 1; t <= FRAME + 200 && fs2 < 0; t++) begin
      tick();
      if (FRAME_START) begin
        if (fs1 < 0) fs1 = t;
        else         fs2 = t;
      end
      if (fs1 >= 0 && fs2 < 0 && !VGA_VS) vs_low++;
      if (prev_vs && !VGA_VS && vs_y < 0) vs_y = int'(PIX_Y);
      prev_vs = VGA_VS;
    end
    check("frame_period", 64'((fs2 >= 0) ? fs2 - fs1 : -1), 64'(FRAME));
    check("vs_low_cycles", 64'(vs_low), 64'(VSY * HT));
    check("vs_start_line", 64'(vs_y), 64'(VD + VF));

    // Mid-frame pattern change takes effect at the next frame
    PAT_SEL = 2'd0;
    do_reset();
    repeat (10 * HT + 1) tick();
    PAT_SEL = 2'd1;
    repeat (10 * HT + 32) tick();
    check("pat_hold_bars_cyan", 64'({VGA_R, VGA_G, VGA_B}), 64'({10'h000, 10'h3FF, 10'h3FF}));
    repeat (FRAME - 20 * HT - 32) tick();
    check("pat_next_frame_origin", 64'({FRAME_START, PIX_X, PIX_Y, VGA_R}),
          64'({1'b1, XW'(0), YW'(0), 10'h000}));
    repeat (32) tick();
    check("pat_next_frame_checker", 64'({VGA_R, VGA_G, VGA_B}), 64'({10'h3FF, 10'h3FF, 10'h3FF}));

    // Reset pulse mid-frame, then clean restart
    PAT_SEL = 2'd0;
    do_reset();
    repeat (20 * HT + 101) tick();
    RST = 1'b1;
    tick();
    check("midreset_values", 64'(act_s), 64'(reset_exp()));
    RST = 1'b0;
    CE  = 1'b0;
    tick();
    check("midreset_hold_ce0", 64'(act_s), 64'(reset_exp()));
    CE = 1'b1;
    tick();
    e = ref_pixel(0, 0, 0);
    check("midreset_first_pixel", 64'(act_s), 64'(e));

    // Randomized CE, pattern and occasional reset against the model
    do_reset();
    for (int i = 0; i < 14000; i++) begin
      CE  = ($urandom_range(0, 3) != 0);
      RST = ($urandom_range(0, 4999) == 0);
      if ($urandom_range(0, 499) == 0) PAT_SEL = 2'($urandom_range(0, 3));
      tick();
    end
    RST = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
